// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding word request
// at a time, and feeds IF/ID through an output register backed by a one-entry skid.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReqValid,
  output logic [31:0] ImemAddr,
  input  logic        ImemReqReady,
  input  logic        ImemRespValid,
  input  logic [31:0] ImemRespData,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;

  state_t      state, state_n;
  logic [31:0] fpc, fpc_n;
  logic [31:0] pend_pc, pend_n;
  logic [31:0] skid_instr, skid_pc;
  logic        skid_ld, out_ld, out_from_skid, flush;
  logic [31:0] ld_pc, ld_instr;

  // Target is word-aligned by construction; the low bits carry no information.
  logic unused_tgt;
  assign unused_tgt = &{1'b0, PCTargetE[1:0]};

  assign ImemReqValid = (state == REQ);
  assign ImemAddr     = fpc;
  assign ld_pc        = out_from_skid ? skid_pc : pend_pc;
  assign ld_instr     = out_from_skid ? skid_instr : ImemRespData;

  always_comb begin
    state_n       = state;
    fpc_n         = fpc;
    pend_n        = pend_pc;
    skid_ld       = 1'b0;
    out_ld        = 1'b0;
    out_from_skid = 1'b0;
    flush         = !StallF;
    if (PCSrcE) begin
      fpc_n = {PCTargetE[31:2], 2'b00};
      flush = 1'b1;
      case (state)
        REQ:       if (ImemReqReady) state_n = DROP;
        WAIT, DROP: state_n = ImemRespValid ? REQ : DROP;
        default:   state_n = REQ;
      endcase
    end else begin
      case (state)
        REQ: if (ImemReqReady) begin
          pend_n  = fpc;
          fpc_n   = fpc + 32'd4;
          state_n = WAIT;
        end
        WAIT: if (ImemRespValid) begin
          // Output slot free (or draining this edge): load directly, else park in skid.
          if (!StallF || !ValidF) begin
            out_ld  = 1'b1;
            state_n = REQ;
          end else begin
            skid_ld = 1'b1;
            state_n = HOLD;
          end
        end
        HOLD: if (!StallF) begin
          out_ld        = 1'b1;
          out_from_skid = 1'b1;
          state_n       = REQ;
        end
        default: if (ImemRespValid) state_n = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= REQ;
      fpc        <= RESET_PC;
      pend_pc    <= '0;
      skid_instr <= '0;
      skid_pc    <= '0;
    end else begin
      state   <= state_n;
      fpc     <= fpc_n;
      pend_pc <= pend_n;
      if (skid_ld) begin
        skid_instr <= ImemRespData;
        skid_pc    <= pend_pc;
      end
    end
  end

  // PCF/PCPlus4F are only rewritten on a load; a flush clears just ValidF/InstrF.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      InstrF   <= NOP_INSTR;
      PCF      <= '0;
      PCPlus4F <= '0;
      ValidF   <= 1'b0;
    end else if (out_ld) begin
      InstrF   <= ld_instr;
      PCF      <= ld_pc;
      PCPlus4F <= ld_pc + 32'd4;
      ValidF   <= 1'b1;
    end else if (flush) begin
      InstrF <= NOP_INSTR;
      ValidF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a
// transaction-level model (outstanding/killed flags, skid slot, output slot).
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, PCSrcE, ImemReqReady, ImemRespValid;
  logic [31:0] PCTargetE, ImemRespData;
  logic        ImemReqValid, ValidF;
  logic [31:0] ImemAddr, InstrF, PCF, PCPlus4F;

  logic        w_ready, w_resp, w_reqv, w_valid;
  logic [31:0] w_data, w_addr, w_instr, w_pcf, w_pc4;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ImemReqValid(ImemReqValid), .ImemAddr(ImemAddr), .ImemReqReady(ImemReqReady),
    .ImemRespValid(ImemRespValid), .ImemRespData(ImemRespData),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF));

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(reset), .StallF(1'b0), .PCSrcE(1'b0), .PCTargetE(32'h0),
    .ImemReqValid(w_reqv), .ImemAddr(w_addr), .ImemReqReady(w_ready),
    .ImemRespValid(w_resp), .ImemRespData(w_data),
    .InstrF(w_instr), .PCF(w_pcf), .PCPlus4F(w_pc4), .ValidF(w_valid));

  // Memory side: one response per accepted request after a chosen latency.
  bit          m_busy;
  int          m_cnt;
  logic [31:0] m_addr;
  int          lat = 1;  // cycles from accept to response; <=0 picks at random

  // Reference model state.
  logic [31:0] e_fpc, e_pend, e_skid_pc, e_skid_i, e_i, e_pc, e_pc4;
  bit          e_busy, e_killed, e_skid_v, e_v;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
  endfunction

  // Called at negedge: drive inputs, cross the posedge, advance memory + model.
  task automatic step(input bit stall, input bit pcsrc, input logic [31:0] tgt,
                      input bit ready, input bit spur);
    bit          real_resp, reqv_s, accept, resp_m, loaded;
    logic [31:0] addr_s, data;
    real_resp     = m_busy && m_cnt == 0;
    data          = real_resp ? mem_word(m_addr) : $urandom;
    StallF        = stall;
    PCSrcE        = pcsrc;
    PCTargetE     = tgt;
    ImemReqReady  = ready;
    ImemRespValid = real_resp || (!m_busy && spur);
    ImemRespData  = data;
    reqv_s = ImemReqValid;
    addr_s = ImemAddr;
    accept = !e_busy && !e_skid_v && ready;
    resp_m = ImemRespValid && e_busy;
    @(posedge clk);
    if (real_resp) m_busy = 0;
    else if (m_busy && m_cnt > 0) m_cnt--;
    if (reqv_s && ready) begin
      m_busy = 1;
      m_addr = addr_s;
      m_cnt  = (lat <= 0) ? int'($urandom_range(0, 2)) : lat - 1;
    end
    if (pcsrc) begin
      e_fpc = {tgt[31:2], 2'b00};
      e_v = 0; e_i = NOP; e_skid_v = 0;
      if (accept) begin e_busy = 1; e_killed = 1; end
      else if (e_busy) begin
        if (resp_m) e_busy = 0; else e_killed = 1;
      end
    end else begin
      loaded = 0;
      if (resp_m) begin
        e_busy = 0;
        if (!e_killed) begin
          if (!stall || !e_v) begin
            e_v = 1; e_i = data; e_pc = e_pend; e_pc4 = e_pend + 32'd4; loaded = 1;
          end else begin
            e_skid_v = 1; e_skid_i = data; e_skid_pc = e_pend;
          end
        end
      end else if (e_skid_v && !stall) begin
        e_v = 1; e_i = e_skid_i; e_pc = e_skid_pc; e_pc4 = e_skid_pc + 32'd4;
        e_skid_v = 0; loaded = 1;
      end
      if (!loaded && !stall) begin e_v = 0; e_i = NOP; end
      if (accept) begin
        e_busy = 1; e_killed = 0; e_pend = e_fpc; e_fpc = e_fpc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    StallF = 0; PCSrcE = 0; PCTargetE = 0; ImemReqReady = 0; ImemRespValid = 0;
    ImemRespData = 0; w_ready = 0; w_resp = 0; w_data = 0;
    reset = 1;
    #3 reset = 0;
    #1;
    n_chk++; if (ValidF !== 1'b0) $display("FAIL rst_valid got %0b exp 0", ValidF); else n_pass++;
    n_chk++; if (InstrF !== NOP) $display("FAIL rst_instr got %h exp %h", InstrF, NOP); else n_pass++;
    n_chk++; if (PCF !== 32'h0 || PCPlus4F !== 32'h0) $display("FAIL rst_pc got %h/%h exp 0/0", PCF, PCPlus4F); else n_pass++;
    n_chk++; if (ImemReqValid !== 1'b1 || ImemAddr !== 32'h0) $display("FAIL rst_req got %0b/%h exp 1/0", ImemReqValid, ImemAddr); else n_pass++;
    n_chk++; if (w_addr !== 32'hFFFF_FFFC) $display("FAIL rst_wrap_addr got %h exp fffffffc", w_addr); else n_pass++;
    m_busy = 0; m_cnt = 0; m_addr = 0;
    e_fpc = 0; e_pend = 0; e_skid_pc = 0; e_skid_i = 0; e_i = NOP; e_pc = 0; e_pc4 = 0;
    e_busy = 0; e_killed = 0; e_skid_v = 0; e_v = 0;
    repeat (3) @(negedge clk);
    reset = 1;
  endtask

  task automatic test_zero_wait;
    lat = 1;
    step(0, 0, 0, 1, 0);
    n_chk++; if (ImemReqValid !== 1'b0 || ValidF !== 1'b0) $display("FAIL zw_wait got req=%0b v=%0b exp 0/0", ImemReqValid, ValidF); else n_pass++;
    step(0, 0, 0, 1, 0);
    n_chk++; if (ValidF !== 1'b1 || InstrF !== 32'h0050_0093) $display("FAIL zw_i0 got %0b/%h exp 1/00500093", ValidF, InstrF); else n_pass++;
    n_chk++; if (PCF !== 32'h0 || PCPlus4F !== 32'h4) $display("FAIL zw_pc0 got %h/%h exp 0/4", PCF, PCPlus4F); else n_pass++;
    n_chk++; if (ImemReqValid !== 1'b1 || ImemAddr !== 32'h4) $display("FAIL zw_req4 got %0b/%h exp 1/4", ImemReqValid, ImemAddr); else n_pass++;
    step(0, 0, 0, 1, 0);
    n_chk++; if (ValidF !== 1'b0 || InstrF !== NOP || PCF !== 32'h0) $display("FAIL zw_consume got %0b/%h/%h exp 0/13/0", ValidF, InstrF, PCF); else n_pass++;
    step(0, 0, 0, 1, 0);
    n_chk++; if (ValidF !== 1'b1 || InstrF !== 32'h0010_0113) $display("FAIL zw_i1 got %0b/%h exp 1/00100113", ValidF, InstrF); else n_pass++;
    n_chk++; if (PCF !== 32'h4 || PCPlus4F !== 32'h8) $display("FAIL zw_pc1 got %h/%h exp 4/8", PCF, PCPlus4F); else n_pass++;
    n_chk++; if (ImemReqValid !== 1'b1 || ImemAddr !== 32'h8) $display("FAIL zw_req8 got %0b/%h exp 1/8", ImemReqValid, ImemAddr); else n_pass++;
  endtask

  task automatic test_stall_skid;
    step(1, 0, 0, 1, 0);
    n_chk++; if (ValidF !== 1'b1 || PCF !== 32'h4 || ImemReqValid !== 1'b0) $display("FAIL sk_hold got %0b/%h/%0b exp 1/4/0", ValidF, PCF, ImemReqValid); else n_pass++;
    step(1, 0, 0, 1, 0);
    n_chk++; if (ValidF !== 1'b1 || InstrF !== 32'h0010_0113 || PCF !== 32'h4) $display("FAIL sk_capture got %0b/%h/%h exp 1/00100113/4", ValidF, InstrF, PCF); else n_pass++;
    step(1, 0, 0, 1, 0);
    n_chk++; if (ImemReqValid !== 1'b0) $display("FAIL sk_noreq got %0b exp 0", ImemReqValid); else n_pass++;
    step(0, 0, 0, 0, 0);
    n_chk++; if (ValidF !== 1'b1 || InstrF !== mem_word(32'h8)) $display("FAIL sk_drain got %0b/%h exp 1/%h", ValidF, InstrF, mem_word(32'h8)); else n_pass++;
    n_chk++; if (PCF !== 32'h8 || PCPlus4F !== 32'hC) $display("FAIL sk_pc got %h/%h exp 8/c", PCF, PCPlus4F); else n_pass++;
    n_chk++; if (ImemReqValid !== 1'b1 || ImemAddr !== 32'hC) $display("FAIL sk_req got %0b/%h exp 1/c", ImemReqValid, ImemAddr); else n_pass++;
  endtask

  task automatic test_redirect_wait;
    lat = 2;
    step(1, 0, 0, 1, 0);
    n_chk++; if (ValidF !== 1'b1 || ImemReqValid !== 1'b0) $display("FAIL rw_pre got %0b/%0b exp 1/0", ValidF, ImemReqValid); else n_pass++;
    step(1, 1, 32'h0000_0103, 0, 0);
    n_chk++; if (ValidF !== 1'b0 || InstrF !== NOP) $display("FAIL rw_flush got %0b/%h exp 0/13", ValidF, InstrF); else n_pass++;
    n_chk++; if (PCF !== 32'h8 || ImemReqValid !== 1'b0) $display("FAIL rw_keep got %h/%0b exp 8/0", PCF, ImemReqValid); else n_pass++;
    step(0, 0, 0, 0, 0);
    n_chk++; if (ValidF !== 1'b0 || ImemReqValid !== 1'b1 || ImemAddr !== 32'h100) $display("FAIL rw_drop got %0b/%0b/%h exp 0/1/100", ValidF, ImemReqValid, ImemAddr); else n_pass++;
  endtask

  task automatic test_redirect_same_cycle;
    lat = 1;
    step(0, 0, 0, 1, 0);
    step(0, 1, 32'h0000_0200, 0, 0);
    n_chk++; if (ValidF !== 1'b0 || ImemReqValid !== 1'b1 || ImemAddr !== 32'h200) $display("FAIL rs_resp got %0b/%0b/%h exp 0/1/200", ValidF, ImemReqValid, ImemAddr); else n_pass++;
    step(0, 1, 32'h0000_0303, 1, 0);
    n_chk++; if (ValidF !== 1'b0 || ImemReqValid !== 1'b0) $display("FAIL rs_acc got %0b/%0b exp 0/0", ValidF, ImemReqValid); else n_pass++;
    step(0, 0, 0, 0, 0);
    n_chk++; if (ValidF !== 1'b0 || ImemReqValid !== 1'b1 || ImemAddr !== 32'h300) $display("FAIL rs_drop got %0b/%0b/%h exp 0/1/300", ValidF, ImemReqValid, ImemAddr); else n_pass++;
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    n_chk++; if (ValidF !== 1'b1 || PCF !== 32'h300 || PCPlus4F !== 32'h304 || InstrF !== mem_word(32'h300)) $display("FAIL rs_resume got %0b/%h/%h/%h exp 1/300/304/%h", ValidF, PCF, PCPlus4F, InstrF, mem_word(32'h300)); else n_pass++;
  endtask

  task automatic test_random;
    lat = 0;
    for (int c = 0; c < 800; c++) begin
      n_chk++; if (ImemReqValid !== (!e_busy && !e_skid_v)) $display("FAIL rnd_reqv c=%0d got %0b exp %0b", c, ImemReqValid, !e_busy && !e_skid_v); else n_pass++;
      n_chk++; if (ImemAddr !== e_fpc) $display("FAIL rnd_addr c=%0d got %h exp %h", c, ImemAddr, e_fpc); else n_pass++;
      n_chk++; if (ValidF !== e_v) $display("FAIL rnd_valid c=%0d got %0b exp %0b", c, ValidF, e_v); else n_pass++;
      n_chk++; if (InstrF !== e_i) $display("FAIL rnd_instr c=%0d got %h exp %h", c, InstrF, e_i); else n_pass++;
      n_chk++; if (PCF !== e_pc || PCPlus4F !== e_pc4) $display("FAIL rnd_pc c=%0d got %h/%h exp %h/%h", c, PCF, PCPlus4F, e_pc, e_pc4); else n_pass++;
      step($urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0, $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
    end
  endtask

  task automatic test_wrap;
    n_chk++; if (w_reqv !== 1'b1 || w_addr !== 32'hFFFF_FFFC) $display("FAIL wr_first got %0b/%h exp 1/fffffffc", w_reqv, w_addr); else n_pass++;
    w_ready = 1;
    @(posedge clk); @(negedge clk);
    w_ready = 0;
    n_chk++; if (w_reqv !== 1'b0 || w_addr !== 32'h0) $display("FAIL wr_fpc got %0b/%h exp 0/0", w_reqv, w_addr); else n_pass++;
    w_resp = 1; w_data = 32'h0050_0093;
    @(posedge clk); @(negedge clk);
    w_resp = 0;
    n_chk++; if (w_valid !== 1'b1 || w_pcf !== 32'hFFFF_FFFC || w_pc4 !== 32'h0) $display("FAIL wr_pc got %0b/%h/%h exp 1/fffffffc/0", w_valid, w_pcf, w_pc4); else n_pass++;
    n_chk++; if (w_reqv !== 1'b1 || w_addr !== 32'h0 || w_instr !== 32'h0050_0093) $display("FAIL wr_next got %0b/%h/%h exp 1/0/00500093", w_reqv, w_addr, w_instr); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_zero_wait;
    test_stall_skid;
    test_redirect_wait;
    test_redirect_same_cycle;
    test_random;
    test_wrap;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", n_chk);
    $fatal(1);
  end

endmodule
